// File: rtl/spc_ctl.sv
// Subroutine-PC stack controller: sequences SPC strobes for microcode and
// the console spy port, and tracks depth with sticky over/underflow flags.
module spc_ctl #(
  parameter int DEPTH_MAX = 32,
  parameter int W         = 19
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         run,
  input  logic         state_read,
  input  logic         state_write,
  input  logic         state_fetch,
  input  logic         uc_push,
  input  logic         uc_pop,
  input  logic [W-1:0] uc_data,
  input  logic         spy_req,
  input  logic         spy_op,
  input  logic [W-1:0] spy_data,
  input  logic         spy_clr,
  output logic         spy_ack,
  output logic [W-1:0] spy_rdata,
  input  logic [W-1:0] spco,
  output logic         spcnt,
  output logic         spush,
  output logic         srp,
  output logic         swp,
  output logic         spc_fetch,
  output logic [W-1:0] spcw,
  output logic [5:0]   depth,
  output logic         ovf,
  output logic         unf,
  output logic         busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_FET,
    S_ACK,
    S_WAITLO
  } state_t;

  state_t         state_q, state_d;
  logic           op_q, op_d;
  logic [5:0]     depth_q, depth_d;
  logic           ovf_q, ovf_d;
  logic           unf_q, unf_d;
  logic           ack_q, ack_d;
  logic [W-1:0]   rdata_q, rdata_d;
  logic           uc_act;
  logic           upd;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= 1'b0;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    unique case (state_q)
      S_IDLE: begin
        if (spy_req && !run) begin
          op_d    = spy_op;
          state_d = spy_op ? S_WR : S_RD;
        end
      end
      S_RD:     state_d = S_FET;
      S_WR:     state_d = S_FET;
      S_FET:    state_d = S_ACK;
      S_ACK:    state_d = S_WAITLO;
      S_WAITLO: if (!spy_req) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  assign busy   = (state_q != S_IDLE);
  assign uc_act = run && !busy;

  always_comb begin
    spcnt     = 1'b0;
    spush     = 1'b0;
    srp       = 1'b0;
    swp       = 1'b0;
    spc_fetch = 1'b0;
    spcw      = '0;
    if (reset) begin
      spcnt = 1'b0;
    end else if (uc_act) begin
      spcnt     = uc_push | uc_pop;
      spush     = uc_push;
      srp       = uc_pop & ~uc_push & state_read;
      swp       = uc_push & state_write;
      spc_fetch = state_fetch;
      spcw      = uc_data;
    end else begin
      unique case (state_q)
        S_RD: begin
          srp   = 1'b1;
          spcnt = 1'b1;
        end
        S_WR: begin
          swp   = 1'b1;
          spcnt = 1'b1;
          spush = 1'b1;
          spcw  = spy_data;
        end
        S_FET: begin
          spc_fetch = 1'b1;
          spcnt     = 1'b1;
          spush     = op_q;
          spcw      = op_q ? spy_data : '0;
        end
        default: spcnt = 1'b0;
      endcase
    end
  end

  assign upd = spc_fetch & spcnt;

  // Depth saturates at both ends; the SPC pointer itself keeps wrapping.
  always_comb begin
    logic set_o, set_u;
    set_o   = 1'b0;
    set_u   = 1'b0;
    depth_d = depth_q;
    if (upd && spush) begin
      if (depth_q == 6'(DEPTH_MAX)) set_o = 1'b1;
      else depth_d = depth_q + 6'd1;
    end else if (upd) begin
      if (depth_q == 6'd0) set_u = 1'b1;
      else depth_d = depth_q - 6'd1;
    end
    ovf_d = (ovf_q & ~spy_clr) | set_o;
    unf_d = (unf_q & ~spy_clr) | set_u;
  end

  always_comb begin
    ack_d   = (state_q == S_ACK);
    rdata_d = rdata_q;
    if (state_q == S_FET && !op_q) rdata_d = spco;
  end

  assign spy_ack   = ack_q;
  assign spy_rdata = rdata_q;
  assign depth     = depth_q;
  assign ovf       = ovf_q;
  assign unf       = unf_q;

endmodule
